// File: rtl/islip_pkg.sv
// Shared types and helpers for the iSLIP iteration controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package islip_pkg;

    // Controller phase encoding; strobes are decoded straight from this.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Width of the iteration counter (iterations 1..7).
    localparam int ITER_W = 3;

    // Base bit index of row `row` in a flattened n*n matrix (row i = bits i*n +: n).
    function automatic int unsigned row_base(input int unsigned n, input int unsigned row);
        return n * row;
    endfunction

endpackage

// File: rtl/islip_match_filter.sv
// Filters one cycle of accept vectors into legal new matches against the unmatched masks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated whenever the controller samples it.
//
// Ports: i_accept (N*N, row i = input i's one-hot accepted output), i_in_mask/i_out_mask
// (1 = still unmatched), o_new_match (legal new matches, same layout), o_in_clr/o_out_clr
// (ports consumed this cycle), o_any_new (at least one legal match), o_err (any illegal row).
module islip_match_filter
    import islip_pkg::*;
#(
    parameter int N = 25
) (
    input  logic [N*N-1:0] i_accept,
    input  logic [N-1:0]   i_in_mask,
    input  logic [N-1:0]   i_out_mask,
    output logic [N*N-1:0] o_new_match,
    output logic [N-1:0]   o_in_clr,
    output logic [N-1:0]   o_out_clr,
    output logic           o_any_new,
    output logic           o_err
);

    logic [N-1:0] row;

    // Rows are walked lowest index first; o_out_clr doubles as the set of outputs
    // already claimed this cycle, so a lower row beats any higher row on the same output.
    always_comb begin
        o_new_match = '0;
        o_in_clr    = '0;
        o_out_clr   = '0;
        o_err       = 1'b0;
        row         = '0;
        for (int i = 0; i < N; i++) begin
            row = i_accept[row_base(N, i) +: N];
            if (row != '0) begin
                if (i_in_mask[i] &&
                    ((row & (row - N'(1))) == '0) &&
                    ((row & i_out_mask & ~o_out_clr) != '0)) begin
                    o_new_match[row_base(N, i) +: N] = row;
                    o_in_clr[i]                      = 1'b1;
                    o_out_clr                        = o_out_clr | row;
                end else begin
                    o_err = 1'b1;
                end
            end
        end
    end

    assign o_any_new = |o_in_clr;

endmodule

// File: rtl/islip_iter_ctrl.sv
// Sequences the grant/accept iterations of one iSLIP slot and accumulates the match matrix.
// Latency: start sampled in cycle c -> o_match_vld in cycle c+2n+1 (n = iterations run).
// Backpressure: i_start honoured only while o_ready=1; otherwise dropped, never queued.
//
// Ports: clk, reset (async, active-low); i_start/o_ready slot handshake; o_grant_en,
// o_accept_en, o_ptr_update strobes to the arbiter arrays; o_in_mask/o_out_mask unmatched
// ports; i_accept per-input accept rows; o_match/o_match_vld result; o_iter, o_err status.
// Build option: define ISLIP_EARLY_EXIT_EN to end the slot after an accept with no new match.
module islip_iter_ctrl
    import islip_pkg::*;
#(
    parameter int N    = 25,
    parameter int P    = 8,
    parameter int ITER = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_ready,
    output logic              o_grant_en,
    output logic              o_accept_en,
    output logic              o_ptr_update,
    output logic [N-1:0]      o_in_mask,
    output logic [N-1:0]      o_out_mask,
    input  logic [N*N-1:0]    i_accept,
    output logic [N*N-1:0]    o_match,
    output logic              o_match_vld,
    output logic [ITER_W-1:0] o_iter,
    output logic              o_err
);

`ifdef ISLIP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    // P only sizes the arbiters next door; it is checked here so a bad build fails early.
    if (P < 1 || ITER < 1 || ITER > 7) begin : g_cfg_check
        $error("islip_iter_ctrl: P must be >= 1 and ITER must be in 1..7");
    end

    state_t              state_q, state_d;
    logic [N-1:0]        in_mask_q, in_mask_d;
    logic [N-1:0]        out_mask_q, out_mask_d;
    logic [N*N-1:0]      match_q, match_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                err_q, err_d;

    logic [N*N-1:0]      new_match;
    logic [N-1:0]        in_clr;
    logic [N-1:0]        out_clr;
    logic                any_new;
    logic                filt_err;

    islip_match_filter #(.N(N)) u_filter (
        .i_accept    (i_accept),
        .i_in_mask   (in_mask_q),
        .i_out_mask  (out_mask_q),
        .o_new_match (new_match),
        .o_in_clr    (in_clr),
        .o_out_clr   (out_clr),
        .o_any_new   (any_new),
        .o_err       (filt_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            in_mask_q  <= '1;
            out_mask_q <= '1;
            match_q    <= '0;
            iter_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_mask_q  <= in_mask_d;
            out_mask_q <= out_mask_d;
            match_q    <= match_d;
            iter_q     <= iter_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_mask_d  = in_mask_q;
        out_mask_d = out_mask_q;
        match_d    = match_q;
        iter_d     = iter_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_GRANT;
                    in_mask_d  = '1;
                    out_mask_d = '1;
                    match_d    = '0;
                    iter_d     = ITER_W'(1);
                    err_d      = 1'b0;
                end
            end
            ST_GRANT: begin
                state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                match_d    = match_q | new_match;
                in_mask_d  = in_mask_q & ~in_clr;
                out_mask_d = out_mask_q & ~out_clr;
                err_d      = err_q | filt_err;
                // Exit test uses the post-accept input mask so a full match ends the slot now.
                if (iter_q == ITER_W'(ITER) || in_mask_d == '0 || (EARLY_EXIT && !any_new)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GRANT;
                    iter_d  = iter_q + ITER_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_ready      = (state_q == ST_IDLE);
    assign o_grant_en   = (state_q == ST_GRANT);
    assign o_accept_en  = (state_q == ST_ACCEPT);
    // Pointers may only advance on first-iteration accepts, otherwise iSLIP loses its
    // desynchronisation property.
    assign o_ptr_update = (state_q == ST_ACCEPT) && (iter_q == ITER_W'(1));
    assign o_match_vld  = (state_q == ST_DONE);
    assign o_in_mask    = in_mask_q;
    assign o_out_mask   = out_mask_q;
    assign o_match      = match_q;
    assign o_iter       = iter_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_islip_iter_ctrl.sv
// Self-checking bench for islip_iter_ctrl with N=4, ITER=3.
// Directed slots followed by randomized slots, each checked against a row-by-row model.
// Build option ISLIP_EARLY_EXIT_EN is mirrored in the model.
module tb_islip_iter_ctrl;

    localparam int N    = 4;
    localparam int ITER = 3;
`ifdef ISLIP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          o_ready;
    logic          o_grant_en;
    logic          o_accept_en;
    logic          o_ptr_update;
    logic [N-1:0]  o_in_mask;
    logic [N-1:0]  o_out_mask;
    logic [N*N-1:0] i_accept;
    logic [N*N-1:0] o_match;
    logic          o_match_vld;
    logic [2:0]    o_iter;
    logic          o_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state: 1 = port still free.
    logic [N-1:0]   m_in;
    logic [N-1:0]   m_out;
    logic [N*N-1:0] m_match;
    bit             m_err;
    bit             m_new;

    islip_iter_ctrl #(.N(N), .P(8), .ITER(ITER)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .i_start      (i_start),
        .o_ready      (o_ready),
        .o_grant_en   (o_grant_en),
        .o_accept_en  (o_accept_en),
        .o_ptr_update (o_ptr_update),
        .o_in_mask    (o_in_mask),
        .o_out_mask   (o_out_mask),
        .i_accept     (i_accept),
        .o_match      (o_match),
        .o_match_vld  (o_match_vld),
        .o_iter       (o_iter),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accept phase: inputs processed in increasing index, each claim is final.
    task automatic model_accept(input logic [N*N-1:0] acc);
        m_new = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic [N-1:0] r;
            int j;
            r = acc[i*N +: N];
            if (r == '0) continue;
            if ($countones(r) != 1) begin
                m_err = 1'b1;
                continue;
            end
            j = 0;
            for (int k = 0; k < N; k++) if (r[k]) j = k;
            if (!m_in[i] || !m_out[j]) begin
                m_err = 1'b1;
                continue;
            end
            m_match[i*N + j] = 1'b1;
            m_in[i]  = 1'b0;
            m_out[j] = 1'b0;
            m_new    = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"},    32'(o_ready), 1);
        chk({pfx, "_grant"},    32'(o_grant_en), 0);
        chk({pfx, "_accept"},   32'(o_accept_en), 0);
        chk({pfx, "_ptr"},      32'(o_ptr_update), 0);
        chk({pfx, "_vld"},      32'(o_match_vld), 0);
        chk({pfx, "_in_mask"},  32'(o_in_mask), 32'hF);
        chk({pfx, "_out_mask"}, 32'(o_out_mask), 32'hF);
        chk({pfx, "_match"},    32'(o_match), 0);
        chk({pfx, "_iter"},     32'(o_iter), 0);
        chk({pfx, "_err"},      32'(o_err), 0);
    endtask

    // Runs one slot from IDLE (called at a negedge). Accept table row it is driven in
    // iteration it+1; other cycles get random junk on i_accept that must be ignored.
    // hold keeps i_start high for the whole slot.
    task automatic run_slot(input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] a2, input bit hold);
        logic [15:0] tab [3];
        int ph;
        int it;
        int cyc;
        bit fin;
        tab[0] = a0; tab[1] = a1; tab[2] = a2;
        chk("ready_before_start", 32'(o_ready), 1);
        m_in = '1; m_out = '1; m_match = '0; m_err = 1'b0;
        it = 0; ph = 1; fin = 1'b0;
        i_start  = 1'b1;
        i_accept = 16'($urandom);
        @(posedge clk); @(negedge clk);
        cyc = 1;
        if (!hold) i_start = 1'b0;
        while (!fin && cyc < 40) begin
            chk("ready_busy", 32'(o_ready), 0);
            chk("grant_en",   32'(o_grant_en), 32'(ph == 1));
            chk("accept_en",  32'(o_accept_en), 32'(ph == 2));
            chk("match_vld",  32'(o_match_vld), 32'(ph == 3));
            if (ph == 1) begin
                i_accept = 16'($urandom);
                ph = 2;
            end else if (ph == 2) begin
                chk("in_mask",    32'(o_in_mask), 32'(m_in));
                chk("out_mask",   32'(o_out_mask), 32'(m_out));
                chk("ptr_update", 32'(o_ptr_update), 32'(it == 0));
                i_accept = tab[it];
                model_accept(tab[it]);
                it++;
                if (it == ITER || m_in == '0 || (EARLY && !m_new)) ph = 3;
                else ph = 1;
            end else begin
                chk("vld_cycle",     32'(cyc), 32'(2*it + 1));
                chk("match",         32'(o_match), 32'(m_match));
                chk("iter",          32'(o_iter), 32'(it));
                chk("err",           32'(o_err), 32'(m_err));
                chk("done_in_mask",  32'(o_in_mask), 32'(m_in));
                chk("done_out_mask", 32'(o_out_mask), 32'(m_out));
                chk("done_ptr",      32'(o_ptr_update), 0);
                i_accept = 16'($urandom);
                fin = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("slot_completed", 32'(fin), 1);
        chk("idle_ready", 32'(o_ready), 1);
        chk("idle_no_vld", 32'(o_match_vld), 0);
        chk("hold_match", 32'(o_match), 32'(m_match));
        chk("hold_iter",  32'(o_iter), 32'(it));
        chk("hold_err",   32'(o_err), 32'(m_err));
    endtask

    function automatic logic [15:0] rand_tab();
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       t[i*N +: N] = 4'b0000;
                1, 2:    t[i*N +: N] = 4'(1 << $urandom_range(0, 3));
                default: t[i*N +: N] = 4'($urandom);
            endcase
        end
        return t;
    endfunction

    initial begin
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_accept = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_rst");

        // Full match in iteration 1: 0->2, 1->0, 2->1, 3->3.
        run_slot(16'h8214, 16'h0000, 16'h0000, 1'b0);
        // 0->1, then 2->3, then nothing.
        run_slot(16'h0002, 16'h0800, 16'h0000, 1'b0);
        // 0->1, then an empty iteration, then 2->3.
        run_slot(16'h0002, 16'h0000, 16'h0800, 1'b0);
        // Rows 0 and 2 both accept output 1; then a continuing empty slot.
        run_slot(16'h0202, 16'h0000, 16'h0000, 1'b0);
        // Conflict followed by legal matches for the losers.
        run_slot(16'h0202, 16'h0100, 16'h4000, 1'b0);
        // Already-matched input 0 tries output 3 in iteration 2.
        run_slot(16'h0002, 16'h0008, 16'h0000, 1'b0);
        // Multi-hot row.
        run_slot(16'h0030, 16'h0020, 16'h0000, 1'b0);
        // i_start held across back-to-back slots.
        run_slot(16'h0002, 16'h0010, 16'h0000, 1'b1);
        run_slot(16'h8214, 16'h0000, 16'h0000, 1'b1);
        i_start = 1'b0;
        @(negedge clk);
        chk("start_drop_idle", 32'(o_ready), 1);

        // Abort a slot in its second accept phase with the async reset.
        i_start = 1'b1;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        i_accept = 16'h0002;
        @(negedge clk);
        i_accept = 16'h0000;
        @(negedge clk);
        chk("abort_in_accept", 32'(o_accept_en), 1);
        chk("abort_pre_match", 32'(o_match), 32'h0002);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_vld", 32'(o_match_vld), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort_release");
        @(negedge clk);
        chk("abort_stays_idle", 32'(o_ready), 1);

        // Randomized slots.
        for (int s = 0; s < 30; s++) begin
            run_slot(rand_tab(), rand_tab(), rand_tab(), 1'($urandom_range(0, 1)));
            i_start = 1'b0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
